// File: rtl/s1neuron_seq.sv
// Time-multiplexes one s1neuron datapath across N neurons: fetch a CRC-coded weight
// vector, present it to the neuron, retry on rfflag, collect H into a result buffer.
module s1neuron_seq #(
    parameter int N        = 4,
    parameter int M        = 8,
    parameter int n        = 32,
    parameter int cl       = 8,
    parameter int MAXRETRY = 3,
    parameter int AW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                mem_en_o,
    output logic [AW-1:0]       mem_addr_o,
    input  logic [M*(n+cl)-1:0] mem_rdata_i,
    output logic [M*(n+cl)-1:0] wcrc_o,
    input  logic                nrn_rfflag_i,
    input  logic [n-1:0]        nrn_h_i,
    output logic [N*n-1:0]      h_out_o,
    output logic [N-1:0]        err_mask_o,
    output logic [7:0]          retry_total_o
);
    localparam int WW = M * (n + cl);
    localparam int RW = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [WW-1:0] wcrc_q, wcrc_d;
    logic [N*n-1:0] h_out_q, h_out_d;
    logic [N-1:0]  err_q, err_d;
    logic [7:0]    rtot_q, rtot_d;
    logic          advance;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rcnt_d  = rcnt_q;
        wcrc_d  = wcrc_q;
        h_out_d = h_out_q;
        err_d   = err_q;
        rtot_d  = rtot_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    rcnt_d  = '0;
                    h_out_d = '0;
                    err_d   = '0;
                    rtot_d  = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                wcrc_d  = mem_rdata_i;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!nrn_rfflag_i) begin
                    h_out_d[int'(idx_q)*n +: n] = nrn_h_i;
                    advance = 1'b1;
                end else if (rcnt_q < RW'(MAXRETRY)) begin
                    rcnt_d  = rcnt_q + RW'(1);
                    if (rtot_q != 8'hFF) rtot_d = rtot_q + 8'd1;
                    state_d = S_FETCH;
                end else begin
                    // retries exhausted: flag the neuron and zero its slot
                    err_d[idx_q] = 1'b1;
                    h_out_d[int'(idx_q)*n +: n] = '0;
                    advance = 1'b1;
                end
                if (advance) begin
                    if (idx_q == AW'(N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        rcnt_d  = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rcnt_q  <= '0;
            wcrc_q  <= '0;
            h_out_q <= '0;
            err_q   <= '0;
            rtot_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rcnt_q  <= rcnt_d;
            wcrc_q  <= wcrc_d;
            h_out_q <= h_out_d;
            err_q   <= err_d;
            rtot_q  <= rtot_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign mem_en_o      = (state_q == S_FETCH);
    assign mem_addr_o    = mem_en_o ? idx_q : '0;
    assign wcrc_o        = wcrc_q;
    assign h_out_o       = h_out_q;
    assign err_mask_o    = err_q;
    assign retry_total_o = rtot_q;
endmodule
